// File: rtl/bus_arb_if.sv
// rtl/bus_arb_if.sv - two requester ports plus one target port for bus_arb
interface bus_arb_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32
);
  logic              in0req;
  logic              in0wr;
  logic [ADDR-1:0]   in0addr;
  logic [DATA-1:0]   in0wdata;
  logic [DATA/8-1:0] in0wstrb;
  logic              in0ack;
  logic [DATA-1:0]   in0rdata;
  logic              in0err;

  logic              in1req;
  logic              in1wr;
  logic [ADDR-1:0]   in1addr;
  logic [DATA-1:0]   in1wdata;
  logic [DATA/8-1:0] in1wstrb;
  logic              in1ack;
  logic [DATA-1:0]   in1rdata;
  logic              in1err;

  logic              outreq;
  logic              outwr;
  logic [ADDR-1:0]   outaddr;
  logic [DATA-1:0]   outwdata;
  logic [DATA/8-1:0] outwstrb;
  logic              outack;
  logic [DATA-1:0]   outrdata;
  logic              outerr;

  // master: the arbiter's view (serves requesters, drives the target)
  modport master (
    input  in0req, in0wr, in0addr, in0wdata, in0wstrb,
    output in0ack, in0rdata, in0err,
    input  in1req, in1wr, in1addr, in1wdata, in1wstrb,
    output in1ack, in1rdata, in1err,
    output outreq, outwr, outaddr, outwdata, outwstrb,
    input  outack, outrdata, outerr
  );

  modport slave (
    output in0req, in0wr, in0addr, in0wdata, in0wstrb,
    input  in0ack, in0rdata, in0err,
    output in1req, in1wr, in1addr, in1wdata, in1wstrb,
    input  in1ack, in1rdata, in1err,
    input  outreq, outwr, outaddr, outwdata, outwstrb,
    output outack, outrdata, outerr
  );
endinterface

// File: rtl/bus_arb.sv
// rtl/bus_arb.sv - two-port alternating-priority arbiter onto one request/ack target with watchdog
module bus_arb #(
  parameter int ADDR     = 32,
  parameter int DATA     = 32,
  parameter int TIMEBITS = 16,
  parameter int TIMEOUT  = 65535
) (
  input  logic      clk,
  input  logic      resetn,
  bus_arb_if.master bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [TIMEBITS-1:0] RELOAD = TIMEBITS'(TIMEOUT);
  localparam bit                  WD_EN  = (TIMEOUT != 0);

  state_t              state, state_nxt;
  logic [1:0]          pending, grant_mask;
  logic                gnt, gnt_nxt, last;
  logic                grant, done, wd_fire, err, sel, outreq_q;
  logic [TIMEBITS-1:0] timer;
  logic                wr_m;
  logic [ADDR-1:0]     addr_m;
  logic [DATA-1:0]     wdata_m;
  logic [DATA/8-1:0]   wstrb_m;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant      = (state == IDLE) && (|pending);
    // on a tie, the port that did not complete last goes first
    gnt_nxt    = (&pending) ? ~last : pending[1];
    grant_mask = grant ? (gnt_nxt ? 2'b10 : 2'b01) : 2'b00;
    wd_fire    = (state == BUSY) && WD_EN && (timer == '0);
    done       = (state == BUSY) && (bus.outack || wd_fire);
    err        = bus.outack ? bus.outerr : 1'b1;

    bus.in0ack   = done && !gnt;
    bus.in1ack   = done && gnt;
    bus.in0err   = done && !gnt && err;
    bus.in1err   = done && gnt && err;
    bus.in0rdata = bus.outrdata;
    bus.in1rdata = bus.outrdata;

    sel     = (state == BUSY) && gnt;
    wr_m    = sel ? bus.in1wr    : bus.in0wr;
    addr_m  = sel ? bus.in1addr  : bus.in0addr;
    wdata_m = sel ? bus.in1wdata : bus.in0wdata;
    wstrb_m = sel ? bus.in1wstrb : bus.in0wstrb;

    bus.outreq   = outreq_q;
    bus.outwr    = wr_m;
    bus.outaddr  = addr_m;
    bus.outwdata = wdata_m;
    bus.outwstrb = wstrb_m;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending  <= 2'b00;
      gnt      <= 1'b0;
      last     <= 1'b1;
      timer    <= '0;
      outreq_q <= 1'b0;
    end else begin
      pending  <= (pending & ~grant_mask) | {bus.in1req, bus.in0req};
      outreq_q <= grant;
      if (grant) begin
        gnt   <= gnt_nxt;
        timer <= RELOAD;
      end else if ((state == BUSY) && (timer != '0)) begin
        timer <= timer - 1'b1;
      end
      if (done) last <= gnt;
    end
  end
endmodule

// File: tb/tb_bus_arb.sv
// tb/tb_bus_arb.sv - directed and randomized checks of bus_arb against a transaction-level model
module tb_bus_arb;
  localparam int TO    = 15;
  localparam int NEVER = 1000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  bus_arb_if #(.ADDR(32), .DATA(32)) bus ();

  bus_arb #(.ADDR(32), .DATA(32), .TIMEBITS(16), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester side
  logic        r_wr[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  logic [3:0]  r_strb[2];
  bit          outst[2], kick[2], req_now[2];
  int          req_cyc[2];

  // reference model: who owns the target and for how long
  bit m_pend[2];
  int m_owner, m_age, m_last;
  bit p_req[2];
  bit p_done;
  int tgt_delay_cur;

  // target behaviour
  bit          rnd_mode = 1'b0;
  bit          late_ack = 1'b0;
  int          tgt_delay = 1;
  logic [31:0] tgt_rdata = '0;
  logic        tgt_err = 1'b0;

  int          cyc = 0;
  int          ack_log[$], ackc_log[$], outreq_log[$];
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; p_req[i] = 0; outst[i] = 0; kick[i] = 0; req_now[i] = 0;
    end
    m_owner = -1; m_age = 0; m_last = 1; p_done = 0; tgt_delay_cur = NEVER;
  endtask

  task automatic model_edge();
    if (m_owner >= 0 && p_done) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_owner < 0 && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) m_owner = 1 - m_last;
      else                        m_owner = m_pend[1] ? 1 : 0;
      m_pend[m_owner] = 0;
      m_age = 0;
      if (rnd_mode) begin
        case ($urandom_range(0, 6))
          5:       tgt_delay_cur = TO;
          6:       tgt_delay_cur = NEVER;
          default: tgt_delay_cur = $urandom_range(0, 4);
        endcase
      end else begin
        tgt_delay_cur = tgt_delay;
      end
    end else if (m_owner >= 0) begin
      m_age++;
    end
    for (int i = 0; i < 2; i++) if (p_req[i]) m_pend[i] = 1;
  endtask

  task automatic apply_req();
    bus.in0req = req_now[0]; bus.in0wr = r_wr[0]; bus.in0addr = r_addr[0];
    bus.in0wdata = r_wdata[0]; bus.in0wstrb = r_strb[0];
    bus.in1req = req_now[1]; bus.in1wr = r_wr[1]; bus.in1addr = r_addr[1];
    bus.in1wdata = r_wdata[1]; bus.in1wstrb = r_strb[1];
  endtask

  task automatic cycle();
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    bit          busy, fire, done;
    int          s;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    for (int i = 0; i < 2; i++) begin
      req_now[i] = 0;
      if (!outst[i] && (rnd_mode ? ($urandom_range(0, 2) == 0) : kick[i])) begin
        if (rnd_mode) begin
          r_wr[i] = 1'($urandom); r_addr[i] = $urandom;
          r_wdata[i] = $urandom; r_strb[i] = 4'($urandom);
        end
        req_now[i] = 1; outst[i] = 1; kick[i] = 0; req_cyc[i] = cyc;
      end
    end
    apply_req();
    busy    = (m_owner >= 0);
    d_ack   = late_ack || (busy && m_age == tgt_delay_cur) ||
              (rnd_mode && !busy && $urandom_range(0, 7) == 0);
    d_rdata = rnd_mode ? $urandom : tgt_rdata;
    d_err   = rnd_mode ? 1'($urandom) : tgt_err;
    bus.outack = d_ack; bus.outrdata = d_rdata; bus.outerr = d_err;
    #3;
    fire = busy && (m_age >= TO);
    done = busy && (d_ack || fire);
    s    = busy ? m_owner : 0;
    check_val("outreq", bus.outreq, busy && m_age == 0);
    check_val("in0ack", bus.in0ack, done && m_owner == 0);
    check_val("in1ack", bus.in1ack, done && m_owner == 1);
    check_val("in0err", bus.in0err, done && m_owner == 0 && (d_ack ? d_err : 1'b1));
    check_val("in1err", bus.in1err, done && m_owner == 1 && (d_ack ? d_err : 1'b1));
    check_val("outwr", bus.outwr, r_wr[s]);
    check_val("outaddr", bus.outaddr, r_addr[s]);
    check_val("outwdata", bus.outwdata, r_wdata[s]);
    check_val("outwstrb", bus.outwstrb, r_strb[s]);
    if (done) check_val("rdata", m_owner == 1 ? bus.in1rdata : bus.in0rdata, d_rdata);
    if (bus.outreq === 1'b1) outreq_log.push_back(cyc);
    if (bus.in0ack === 1'b1 || bus.in1ack === 1'b1) begin
      ack_log.push_back(bus.in1ack ? 1 : 0);
      ackc_log.push_back(cyc);
      obs_rdata = bus.in1ack ? bus.in1rdata : bus.in0rdata;
      obs_err   = bus.in1ack ? bus.in1err : bus.in0err;
    end
    for (int i = 0; i < 2; i++) p_req[i] = req_now[i];
    p_done = done;
    if (done) outst[m_owner] = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((m_owner >= 0 || outst[0] || outst[1] || kick[0] || kick[1]) && n < 300);
    check_val("idle_reached", n < 300, 1);
  endtask

  task automatic clear_logs();
    ack_log.delete(); ackc_log.delete(); outreq_log.delete();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    bus.in0req = 1'b0; bus.in1req = 1'b0; bus.outack = 1'b0;
    #1;
    check_val("rst_outreq", bus.outreq, 0);
    check_val("rst_in0ack", bus.in0ack, 0);
    check_val("rst_in1ack", bus.in1ack, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_wr[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0;
    end
    model_reset();
    apply_req();
    bus.outack = 1'b0; bus.outrdata = '0; bus.outerr = 1'b0;

    @(posedge clk);
    #1;
    check_val("reset_outreq", bus.outreq, 0);
    check_val("reset_in0ack", bus.in0ack, 0);
    check_val("reset_in1ack", bus.in1ack, 0);
    check_val("reset_in0err", bus.in0err, 0);
    check_val("reset_in1err", bus.in1err, 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // port 0 read, 3-cycle target
    clear_logs();
    r_wr[0] = 0; r_addr[0] = 32'h100;
    tgt_delay = 3; tgt_rdata = 32'hDEAD_BEEF; tgt_err = 0;
    kick[0] = 1;
    wait_idle();
    check_val("t1_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1 && outreq_log.size() == 1) begin
      check_val("t1_port", ack_log[0], 0);
      check_val("t1_latency", outreq_log[0] - req_cyc[0], 2);
      check_val("t1_ackdelay", ackc_log[0] - outreq_log[0], 3);
      check_val("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
      check_val("t1_err", obs_err, 0);
    end

    // port 1 write with target error
    clear_logs();
    r_wr[1] = 1; r_addr[1] = 32'h40; r_wdata[1] = 32'h1234_5678; r_strb[1] = 4'hF;
    tgt_delay = 2; tgt_err = 1;
    kick[1] = 1;
    wait_idle();
    check_val("t2_noutreq", outreq_log.size(), 1);
    check_val("t2_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      check_val("t2_port", ack_log[0], 1);
      check_val("t2_err", obs_err, 1);
    end

    // simultaneous requests, then port 1 during port 0 BUSY and port 0 right after
    clear_logs();
    tgt_err = 0; tgt_delay = 2;
    r_wr[0] = 0; r_addr[0] = 32'h200;
    kick[0] = 1; kick[1] = 1;
    wait_idle();
    kick[0] = 1;
    for (int n = 0; n < 20 && m_owner != 0; n++) cycle();
    kick[1] = 1;
    for (int n = 0; n < 40 && outst[0]; n++) cycle();
    kick[0] = 1;
    wait_idle();
    check_val("t3_nacks", ack_log.size(), 5);
    if (ack_log.size() == 5) begin
      check_val("t3_ord0", ack_log[0], 0);
      check_val("t3_ord1", ack_log[1], 1);
      check_val("t3_ord2", ack_log[2], 0);
      check_val("t3_ord3", ack_log[3], 1);
      check_val("t3_ord4", ack_log[4], 0);
    end

    // watchdog, then a late ack in IDLE
    clear_logs();
    tgt_delay = NEVER;
    kick[0] = 1;
    wait_idle();
    check_val("t4_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1 && outreq_log.size() == 1) begin
      check_val("t4_wd_delay", ackc_log[0] - outreq_log[0], TO);
      check_val("t4_err", obs_err, 1);
    end
    late_ack = 1;
    cycle();
    late_ack = 0;
    repeat (3) cycle();
    check_val("t4_late_ignored", ack_log.size(), 1);

    // zero-wait target with a queued second port
    clear_logs();
    tgt_delay = 0;
    kick[0] = 1; kick[1] = 1;
    wait_idle();
    check_val("t5_noutreq", outreq_log.size(), 2);
    if (outreq_log.size() == 2 && ackc_log.size() == 2) begin
      check_val("t5_same_cycle", ackc_log[0], outreq_log[0]);
      check_val("t5_next_outreq", outreq_log[1] - ackc_log[0], 2);
    end

    // reset mid-BUSY with the other port pending
    tgt_delay = NEVER;
    kick[0] = 1; kick[1] = 1;
    for (int n = 0; n < 20 && !(m_owner >= 0 && m_age >= 3); n++) cycle();
    mid_reset();
    clear_logs();
    repeat (6) cycle();
    check_val("t6_pending_clr", outreq_log.size(), 0);
    tgt_delay = 1; tgt_rdata = 32'hA5A5_0001;
    r_wr[0] = 0; r_addr[0] = 32'h300;
    kick[0] = 1;
    wait_idle();
    check_val("t6_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1) check_val("t6_rdata", obs_rdata, 32'hA5A5_0001);

    // randomized traffic
    rnd_mode = 1;
    repeat (3000) cycle();
    rnd_mode = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter ADDR, default 32, address width of all address ports.
REQ-002 Parameter DATA, default 32, data width; strobe width is DATA/8.
REQ-003 Parameter TIMEBITS, default 16, width of the watchdog counter.
REQ-004 Parameter TIMEOUT, default 65535, watchdog reload value in cycles; 0 disables the watchdog.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 in0req  in  1  port 0 request, one-cycle pulse.
REQ-008 in0wr  in  1  port 0 direction: 1 = write, 0 = read.
REQ-009 in0addr  in  ADDR  port 0 address.
REQ-010 in0wdata  in  DATA  port 0 write data.
REQ-011 in0wstrb  in  DATA/8  port 0 write byte strobes.
REQ-012 in0ack  out  1  port 0 completion pulse.
REQ-013 in0rdata  out  DATA  port 0 read data, valid with in0ack.
REQ-014 in0err  out  1  port 0 error flag, valid with in0ack.
REQ-015 in1req, in1wr, in1addr, in1wdata, in1wstrb, in1ack, in1rdata, in1err: same directions, widths and meanings as REQ-007..014, for port 1.
REQ-016 outreq  out  1  target request, one-cycle pulse.
REQ-017 outwr, outaddr (ADDR), outwdata (DATA), outwstrb (DATA/8)  out  target command fields.
REQ-018 outack  in  1  target completion.
REQ-019 outrdata  in  DATA  target read data; outerr  in  1  target error.

Function
REQ-020 Each requester SHALL hold its wr/addr/wdata/wstrb stable from its req cycle through its ack cycle, and SHALL NOT issue a new req before its ack; the block does not check violations.
REQ-021 The block SHALL keep one pending bit per port: set on the edge after the inNreq cycle, cleared on the edge that grants that port.
REQ-022 The block SHALL use two states, IDLE and BUSY, with a 1-bit gnt register and a 1-bit last register.
REQ-023 IDLE with any pending bit set: gnt <= the pending port; if both ports are pending, gnt <= !last; state <= BUSY; timer <= TIMEOUT.
REQ-024 outreq SHALL be 1 only in the first BUSY cycle after a grant.
REQ-025 outwr/outaddr/outwdata/outwstrb SHALL be multiplexed from port gnt in BUSY and from port 0 in IDLE.
REQ-026 In BUSY, if outack or the watchdog fires: assert in{gnt}ack combinationally in that cycle; last <= gnt; state <= IDLE.
REQ-027 outack may arrive in the same cycle as outreq (zero-wait target).
REQ-028 in0rdata and in1rdata SHALL both carry outrdata combinationally.
REQ-029 inNerr = inNack & (outerr | watchdog fired); if outack and the watchdog fire together, the ack wins and err = outerr.
REQ-030 Timer behaviour:
- decrements each BUSY cycle while nonzero;
- the watchdog fires in BUSY when timer == 0 and TIMEOUT != 0, i.e. TIMEOUT cycles after the outreq cycle.
REQ-031 outack in IDLE (e.g. a late ack after a timeout) SHALL be ignored.
REQ-032 A request on the non-granted port during BUSY SHALL be latched and served after the current transaction.
REQ-033 Latency:
- req at cycle T -> outreq at T+2;
- after a completion the block spends one IDLE cycle before the next outreq.

Reset
REQ-034 On resetn low, asynchronously:
- state = IDLE; pending = 0; gnt = 0; last = 1; timer = 0;
- outreq, in0ack, in1ack, in0err, in1err = 0.
REQ-035 Reset during BUSY SHALL abandon the transaction with no ack to either port.

Verification
REQ-036 Port 0 read of 0x100; target acks 3 cycles after outreq with 0xDEADBEEF -> one-cycle in0ack, in0rdata 0xDEADBEEF, in0err 0, in1ack stays 0.
REQ-037 Port 1 write: addr 0x40, wdata 0x12345678, wstrb 0xF; target acks with outerr=1 -> outwr 1, outaddr 0x40, single outreq pulse, in1ack with in1err 1.
REQ-038 Both ports request in the same cycle after reset -> port 0 served first, then port 1. Then port 1 re-requests during port 0 BUSY and port 0 re-requests right after -> port 1 served before port 0.
REQ-039 TIMEOUT=15, target never acks -> in0ack with in0err 1 exactly 15 cycles after outreq; a later outack is ignored and produces no ack.
REQ-040 outack in the same cycle as outreq -> ack to the requester in that cycle; next queued port's outreq follows 2 cycles later.
REQ-041 resetn pulsed low mid-BUSY -> outreq/acks 0 immediately, pending cleared; after release, a fresh port 0 request completes normally.
